mul_error_profiler: RTL

- Hardware self-test engine that drives an 8x8 multiplier under test and profiles its error.
- Sweeps every unordered operand pair num1 = 1..255, num2 = 1..num1, giving 32640 pairs.
- Each pair's 15-bit product is compared with the exact 16-bit product, and per-bit mismatch counters are accumulated.
- Sits beside the multiplier in the approximate-multiplier evaluation top. Results are read back through an indexed register port.

---
 rtl/mul_error_profiler.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mul_error_profiler.sv
// mul_error_profiler: self-test engine that sweeps every unordered 8x8 operand
// pair (num1 = 1..255, num2 = 1..num1) through a multiplier under test and
// accumulates per-bit mismatch counts between its 15-bit product and the exact
// 16-bit product. Results are read back through rd_idx / rd_data.
// Optional build macro MUL_ERR_MAG_EN adds err_sum / err_max magnitude outputs.
module mul_error_profiler #(
  parameter int PROD_LAT = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [7:0]       num1,
  output logic [7:0]       num2,
  input  logic [14:0]      prod,
  output logic             busy,
  output logic             done,
  input  logic [4:0]       rd_idx,
  output logic [CNT_W-1:0] rd_data
`ifdef MUL_ERR_MAG_EN
  ,
  output logic [31:0]      err_sum,
  output logic [15:0]      err_max
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // DRAIN lasts until the last issued pair has been compared; at least one cycle.
  localparam int DRAIN_CYC = (PROD_LAT > 1) ? PROD_LAT : 1;
  localparam int DW        = $clog2(DRAIN_CYC + 1);
  localparam logic [DW-1:0]    DRAIN_LOAD = DW'(DRAIN_CYC - 1);
  localparam logic [DW-1:0]    DRAIN_ONE  = DW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t          r_state;
  logic [7:0]      r_num1;
  logic [7:0]      r_num2;
  logic            r_busy;
  logic            r_done;
  logic [DW-1:0]   r_drain_cnt;

  logic            w_clear;
  logic            w_issue;
  logic [15:0]     w_exact;
  logic            w_cmp_vld;
  logic [15:0]     w_cmp_exact;
  logic [15:0]     w_err;

  logic [CNT_W-1:0] r_freq [16];
  logic [CNT_W-1:0] r_pairs;

  assign num1 = r_num1;
  assign num2 = r_num2;
  assign busy = r_busy;
  assign done = r_done;

  // A new sweep can only begin from IDLE or DONE; start while busy is ignored.
  assign w_clear = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_issue = (r_state == S_RUN);
  assign w_exact = {8'd0, r_num1} * {8'd0, r_num2};

  // Sweep sequencer: operand generation, drain timing and status flags.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_num1      <= 8'd0;
      r_num2      <= 8'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_RUN;
            r_num1  <= 8'd1;
            r_num2  <= 8'd1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        S_RUN: begin
          if ((r_num1 == 8'd255) && (r_num2 == 8'd255)) begin
            // Last pair issued: operands hold at (255,255).
            r_state     <= S_DRAIN;
            r_drain_cnt <= DRAIN_LOAD;
          end else if (r_num2 == r_num1) begin
            r_num1 <= r_num1 + 8'd1;
            r_num2 <= 8'd1;
          end else begin
            r_num2 <= r_num2 + 8'd1;
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == '0) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - DRAIN_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag pipeline: aligns the exact product with a multiplier of PROD_LAT cycles.
  generate
    if (PROD_LAT == 0) begin : g_comb
      assign w_cmp_vld   = w_issue;
      assign w_cmp_exact = w_exact;
    end else begin : g_pipe
      logic [PROD_LAT-1:0] r_pipe_vld;
      logic [15:0]         r_pipe_exact [PROD_LAT];

      // Valid tags are reset so an abort empties the pipeline.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_pipe_vld <= '0;
        end else begin
          r_pipe_vld[0] <= w_issue;
          for (int i = 1; i < PROD_LAT; i++) r_pipe_vld[i] <= r_pipe_vld[i-1];
        end
      end

      // Product payload shifts unconditionally alongside its tag.
      // NOTE: data-only storage needs no reset; the valid tag qualifies it.
      always_ff @(posedge clk) begin
        r_pipe_exact[0] <= w_exact;
        for (int i = 1; i < PROD_LAT; i++) r_pipe_exact[i] <= r_pipe_exact[i-1];
      end

      assign w_cmp_vld   = r_pipe_vld[PROD_LAT-1];
      assign w_cmp_exact = r_pipe_exact[PROD_LAT-1];
    end
  endgenerate

  // Bit 15 of the DUT is implicitly 0, so it flags every product >= 32768.
  assign w_err = {1'b0, prod} ^ w_cmp_exact;

  // Per-bit mismatch counters and pair counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      for (int i = 0; i < 16; i++) r_freq[i] <= '0;
      r_pairs <= '0;
    end else if (w_cmp_vld) begin
      for (int i = 0; i < 16; i++) begin
        if (w_err[i] && (r_freq[i] != CNT_MAX)) r_freq[i] <= r_freq[i] + CNT_ONE;
      end
      if (r_pairs != CNT_MAX) r_pairs <= r_pairs + CNT_ONE;
    end
  end

  // Indexed readout of live counter values; unused indices read zero.
  // NOTE: the output gets a default before any branch so no latch is inferred.
  always_comb begin
    rd_data = '0;
    if (rd_idx < 5'd16) begin
      rd_data = r_freq[rd_idx[3:0]];
    end else if (rd_idx == 5'd16) begin
      rd_data = r_pairs;
    end
  end

`ifdef MUL_ERR_MAG_EN
  logic [15:0] w_prod_ext;
  logic [15:0] w_abs;
  logic [32:0] w_sum_next;
  logic [31:0] r_err_sum;
  logic [15:0] r_err_max;

  assign w_prod_ext = {1'b0, prod};
  assign w_abs      = (w_cmp_exact >= w_prod_ext) ? (w_cmp_exact - w_prod_ext)
                                                  : (w_prod_ext - w_cmp_exact);
  assign w_sum_next = {1'b0, r_err_sum} + {17'd0, w_abs};

  // Error magnitude statistics, updated on the same cycles as the counters.
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_err_sum <= '0;
      r_err_max <= '0;
    end else if (w_cmp_vld) begin
      r_err_sum <= w_sum_next[32] ? 32'hFFFF_FFFF : w_sum_next[31:0];
      if (w_abs > r_err_max) r_err_max <= w_abs;
    end
  end

  assign err_sum = r_err_sum;
  assign err_max = r_err_max;
`endif

endmodule
